// File: rtl/mac_header_parser.sv
// Ingress MAC header parser: captures DA/SA from the first 12 frame bytes and
// raises a held request (addresses, learn/broadcast flags, port) to the address table.
module mac_header_parser #(
    parameter int NUM_PORTS = 8,
    parameter int PORT_ID   = 0,
    localparam int P        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data_i,
    input  logic         rx_valid_i,
    input  logic         rx_sop_i,
    input  logic         rx_eop_i,
    output logic         req_valid_o,
    input  logic         req_ready_i,
    output logic [47:0]  mac_addr_read_o,
    output logic [47:0]  mac_addr_learn_o,
    output logic         learn_en_o,
    output logic         bcast_o,
    output logic [P-1:0] port_num_o,
    output logic         runt_o,
    output logic         drop_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_DST, S_SRC, S_WAIT, S_PAYLOAD, S_DROP
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [47:0] r_da_cap;
    logic [47:0] r_sa_cap;
    logic        r_req_valid;
    logic [47:0] r_mac_read;
    logic [47:0] r_mac_learn;
    logic        r_learn;
    logic        r_bcast;
    logic        r_runt;
    logic        r_drop;

    state_t      w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [47:0] w_da_nxt;
    logic [47:0] w_sa_nxt;
    logic        w_runt;
    logic        w_drop;
    logic        w_hdr_done;
    logic        w_accept;
    logic        w_pend;

    assign w_accept = r_req_valid & req_ready_i;
    // A request accepted this very cycle does not block a new sop.
    assign w_pend   = r_req_valid & ~req_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_da_nxt    = r_da_cap;
        w_sa_nxt    = r_sa_cap;
        w_runt      = 1'b0;
        w_drop      = 1'b0;
        w_hdr_done  = 1'b0;
        if (rx_valid_i) begin
            if (rx_sop_i && r_state != S_DROP) begin
                if (w_pend) begin
                    w_drop      = 1'b1;
                    w_state_nxt = rx_eop_i ? S_IDLE : S_DROP;
                end else begin
                    w_cnt_nxt = 4'd0;
                    w_da_nxt  = {40'd0, rx_data_i};
                    if (rx_eop_i) begin
                        w_runt      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DST;
                    end
                end
            end else begin
                case (r_state)
                    S_DST: begin
                        w_da_nxt  = {r_da_cap[39:0], rx_data_i};
                        w_cnt_nxt = r_cnt + 4'd1;
                        if (rx_eop_i) begin
                            w_runt      = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else if (r_cnt == 4'd4) begin
                            w_state_nxt = S_SRC;
                        end
                    end
                    S_SRC: begin
                        w_sa_nxt  = {r_sa_cap[39:0], rx_data_i};
                        w_cnt_nxt = r_cnt + 4'd1;
                        if (r_cnt == 4'd10) begin
                            w_hdr_done  = 1'b1;
                            w_state_nxt = rx_eop_i ? S_IDLE : S_WAIT;
                        end else if (rx_eop_i) begin
                            w_runt      = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                    S_WAIT: begin
                        if (rx_eop_i)     w_state_nxt = S_IDLE;
                        else if (!w_pend) w_state_nxt = S_PAYLOAD;
                    end
                    S_PAYLOAD, S_DROP: begin
                        if (rx_eop_i) w_state_nxt = S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_da_cap <= 48'd0;
            r_sa_cap <= 48'd0;
            r_runt   <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_da_cap <= w_da_nxt;
            r_sa_cap <= w_sa_nxt;
            r_runt   <= w_runt;
            r_drop   <= w_drop;
        end
    end

    // Request outputs are held until the handshake, then cleared to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_valid <= 1'b0;
            r_mac_read  <= 48'd0;
            r_mac_learn <= 48'd0;
            r_learn     <= 1'b0;
            r_bcast     <= 1'b0;
        end else if (w_hdr_done) begin
            r_req_valid <= 1'b1;
            r_mac_read  <= r_da_cap;
            r_mac_learn <= w_sa_nxt;
            r_learn     <= ~w_sa_nxt[40] & (|w_sa_nxt);
            r_bcast     <= &r_da_cap;
        end else if (w_accept) begin
            r_req_valid <= 1'b0;
            r_mac_read  <= 48'd0;
            r_mac_learn <= 48'd0;
            r_learn     <= 1'b0;
            r_bcast     <= 1'b0;
        end
    end

    assign req_valid_o      = r_req_valid;
    assign mac_addr_read_o  = r_mac_read;
    assign mac_addr_learn_o = r_mac_learn;
    assign learn_en_o       = r_learn;
    assign bcast_o          = r_bcast;
    assign port_num_o       = r_req_valid ? P'(PORT_ID) : '0;
    assign runt_o           = r_runt;
    assign drop_o           = r_drop;

endmodule

// File: tb/tb_mac_header_parser.sv
// Scoreboard bench for mac_header_parser: expected requests are queued as frames
// are sent and popped by a monitor at each handshake.
module tb_mac_header_parser;

    localparam int NP  = 8;
    localparam int PID = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data_i = 8'd0;
    logic        rx_valid_i = 1'b0;
    logic        rx_sop_i = 1'b0;
    logic        rx_eop_i = 1'b0;
    logic        req_valid_o;
    logic        req_ready_i = 1'b0;
    logic [47:0] mac_addr_read_o;
    logic [47:0] mac_addr_learn_o;
    logic        learn_en_o;
    logic        bcast_o;
    logic [2:0]  port_num_o;
    logic        runt_o;
    logic        drop_o;

    mac_header_parser #(.NUM_PORTS(NP), .PORT_ID(PID)) dut (
        .clk(clk), .reset(reset),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .rx_sop_i(rx_sop_i), .rx_eop_i(rx_eop_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .mac_addr_read_o(mac_addr_read_o), .mac_addr_learn_o(mac_addr_learn_o),
        .learn_en_o(learn_en_o), .bcast_o(bcast_o), .port_num_o(port_num_o),
        .runt_o(runt_o), .drop_o(drop_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [47:0] da;
        logic [47:0] sa;
        logic        learn;
        logic        bcast;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   runt_cnt = 0;
    int   drop_cnt = 0;
    int   acc_cnt = 0;

    // Monitor: count pulses, pop the scoreboard at each handshake.
    always @(negedge clk) begin
        if (reset) begin
            if (runt_o) runt_cnt++;
            if (drop_o) drop_cnt++;
            if (req_valid_o && req_ready_i) begin
                acc_cnt++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_req got da=%h sa=%h with empty scoreboard",
                             mac_addr_read_o, mac_addr_learn_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({mac_addr_read_o, mac_addr_learn_o, learn_en_o, bcast_o, port_num_o}
                        !== {e.da, e.sa, e.learn, e.bcast, 3'(PID)}) begin
                        n_err++;
                        $display("FAIL req_fields got da=%h sa=%h l=%b b=%b p=%0d want da=%h sa=%h l=%b b=%b p=%0d",
                                 mac_addr_read_o, mac_addr_learn_o, learn_en_o, bcast_o, port_num_o,
                                 e.da, e.sa, e.learn, e.bcast, PID);
                    end
                end
            end
        end
    end

    function automatic logic [7:0] fbyte(input logic [47:0] da, input logic [47:0] sa, input int i);
        if (i < 6)  return da[47-8*i -: 8];
        if (i < 12) return sa[47-8*(i-6) -: 8];
        return 8'(i);
    endfunction

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic sop, input logic eop);
        rx_data_i  = d;
        rx_valid_i = 1'b1;
        rx_sop_i   = sop;
        rx_eop_i   = eop;
        @(posedge clk);
        #1;
        rx_valid_i = 1'b0;
        rx_sop_i   = 1'b0;
        rx_eop_i   = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] da, input logic [47:0] sa, input int len, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle_cycles(1);
            drive_byte(fbyte(da, sa, i), i == 0, i == len - 1);
        end
    endtask

    task automatic test_reset;
        #2;
        n_vec++;
        if ({req_valid_o, mac_addr_read_o, mac_addr_learn_o, learn_en_o, bcast_o, port_num_o, runt_o, drop_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%b da=%h sa=%h l=%b b=%b p=%0d r=%b d=%b want all 0",
                     req_valid_o, mac_addr_read_o, mac_addr_learn_o, learn_en_o, bcast_o, port_num_o, runt_o, drop_o);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_basic;
        logic [47:0] da, sa;
        da = 48'h001122334455;
        sa = 48'h00AABBCCDDEE;
        req_ready_i = 1'b1;
        exp_q.push_back('{da, sa, 1'b1, 1'b0});
        for (int i = 0; i < 64; i++) begin
            drive_byte(fbyte(da, sa, i), i == 0, i == 63);
            if (i == 10) begin
                n_vec++;
                if (req_valid_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL basic_early_req got %b want 0", req_valid_o);
                end
            end
            if (i == 11) begin
                n_vec++;
                if (req_valid_o !== 1'b1 || port_num_o !== 3'(PID)) begin
                    n_err++;
                    $display("FAIL basic_req_rise got v=%b p=%0d want v=1 p=%0d", req_valid_o, port_num_o, PID);
                end
            end
            if (i == 12) begin
                n_vec++;
                if ({req_valid_o, learn_en_o, bcast_o, port_num_o} !== '0) begin
                    n_err++;
                    $display("FAIL basic_req_fall got v=%b l=%b b=%b p=%0d want 0", req_valid_o, learn_en_o, bcast_o, port_num_o);
                end
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_bcast;
        req_ready_i = 1'b1;
        exp_q.push_back('{48'hFFFFFFFFFFFF, 48'h01005E000001, 1'b0, 1'b1});
        send_frame(48'hFFFFFFFFFFFF, 48'h01005E000001, 20, 1'b0);
        exp_q.push_back('{48'h123456789ABC, 48'h000000000000, 1'b0, 1'b0});
        send_frame(48'h123456789ABC, 48'h000000000000, 12, 1'b0);
        idle_cycles(3);
    endtask

    task automatic test_runt;
        int r0, a0;
        req_ready_i = 1'b1;
        r0 = runt_cnt;
        a0 = acc_cnt;
        send_frame(48'h0A0A0A0A0A0A, 48'h0B0B0B0B0B0B, 9, 1'b0);
        idle_cycles(3);
        n_vec++;
        if (runt_cnt - r0 != 1 || acc_cnt != a0) begin
            n_err++;
            $display("FAIL runt_9 got runts=%0d reqs=%0d want runts=1 reqs=0", runt_cnt - r0, acc_cnt - a0);
        end
        r0 = runt_cnt;
        drive_byte(8'h55, 1'b1, 1'b1);
        idle_cycles(2);
        n_vec++;
        if (runt_cnt - r0 != 1 || acc_cnt != a0) begin
            n_err++;
            $display("FAIL runt_1byte got runts=%0d reqs=%0d want runts=1 reqs=0", runt_cnt - r0, acc_cnt - a0);
        end
    endtask

    task automatic test_drop;
        int d0, a0;
        logic [47:0] da;
        da = 48'h0A0B0C0D0E0F;
        req_ready_i = 1'b0;
        d0 = drop_cnt;
        a0 = acc_cnt;
        exp_q.push_back('{da, 48'h001020304050, 1'b1, 1'b0});
        send_frame(da, 48'h001020304050, 16, 1'b0);
        send_frame(48'h111111111111, 48'h222222222222, 20, 1'b0);
        idle_cycles(64);
        n_vec++;
        if (drop_cnt - d0 != 1 || req_valid_o !== 1'b1 || mac_addr_read_o !== da || acc_cnt != a0) begin
            n_err++;
            $display("FAIL drop_hold got drops=%0d v=%b da=%h want drops=1 v=1 da=%h",
                     drop_cnt - d0, req_valid_o, mac_addr_read_o, da);
        end
        req_ready_i = 1'b1;
        idle_cycles(3);
        n_vec++;
        if (acc_cnt - a0 != 1 || req_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL drop_accept got accepts=%0d v=%b want accepts=1 v=0", acc_cnt - a0, req_valid_o);
        end
    endtask

    task automatic test_gaps;
        req_ready_i = 1'b1;
        exp_q.push_back('{48'h001122334455, 48'h00AABBCCDDEE, 1'b1, 1'b0});
        send_frame(48'h001122334455, 48'h00AABBCCDDEE, 64, 1'b1);
        idle_cycles(2);
    endtask

    task automatic test_restart;
        int r0;
        req_ready_i = 1'b1;
        r0 = runt_cnt;
        for (int i = 0; i < 7; i++) drive_byte(8'hC0 + 8'(i), i == 0, 1'b0);
        exp_q.push_back('{48'h665544332211, 48'h020000000001, 1'b1, 1'b0});
        send_frame(48'h665544332211, 48'h020000000001, 16, 1'b0);
        idle_cycles(2);
        n_vec++;
        if (runt_cnt != r0) begin
            n_err++;
            $display("FAIL restart_runt got runts=%0d want 0", runt_cnt - r0);
        end
    endtask

    task automatic test_back_to_back;
        int d0;
        d0 = drop_cnt;
        req_ready_i = 1'b0;
        exp_q.push_back('{48'hA1A2A3A4A5A6, 48'h00B1B2B3B4B5, 1'b1, 1'b0});
        send_frame(48'hA1A2A3A4A5A6, 48'h00B1B2B3B4B5, 14, 1'b0);
        idle_cycles(2);
        exp_q.push_back('{48'hC1C2C3C4C5C6, 48'h03D1D2D3D4D5, 1'b0, 1'b0});
        req_ready_i = 1'b1;
        send_frame(48'hC1C2C3C4C5C6, 48'h03D1D2D3D4D5, 14, 1'b0);
        idle_cycles(2);
        n_vec++;
        if (drop_cnt != d0) begin
            n_err++;
            $display("FAIL b2b_drop got drops=%0d want 0", drop_cnt - d0);
        end
    endtask

    task automatic test_midreset;
        logic [47:0] da, sa;
        da = 48'h00DEADBEEF00;
        sa = 48'h00CAFEF00D11;
        req_ready_i = 1'b0;
        send_frame(48'h0F0F0F0F0F0F, 48'h001111111111, 14, 1'b0);
        reset = 1'b0;
        #1;
        n_vec++;
        if ({req_valid_o, mac_addr_read_o, mac_addr_learn_o, learn_en_o, bcast_o, port_num_o} !== '0) begin
            n_err++;
            $display("FAIL reset_pending got v=%b da=%h want all 0", req_valid_o, mac_addr_read_o);
        end
        idle_cycles(1);
        reset = 1'b1;
        req_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) drive_byte(fbyte(da, sa, i), i == 0, 1'b0);
        reset = 1'b0;
        #1;
        n_vec++;
        if ({req_valid_o, runt_o, drop_o, learn_en_o, bcast_o} !== '0) begin
            n_err++;
            $display("FAIL reset_midframe got v=%b r=%b d=%b want 0", req_valid_o, runt_o, drop_o);
        end
        idle_cycles(1);
        reset = 1'b1;
        for (int i = 8; i < 20; i++) drive_byte(fbyte(da, sa, i), 1'b0, i == 19);
        exp_q.push_back('{da, sa, 1'b1, 1'b0});
        send_frame(da, sa, 20, 1'b0);
        idle_cycles(3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bcast();
        test_runt();
        test_drop();
        test_gaps();
        test_restart();
        test_back_to_back();
        test_midreset();
        idle_cycles(4);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d outstanding want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
